// File: rtl/luma_pack_pkg.sv
// luma_pack_pkg: widths and types shared by the luma packer slice.
// Converter latency is in enabled edges.
package luma_pack_pkg;
   localparam int LUMA_W       = 8;
   localparam int PIX_PER_WORD = 4;
   localparam int CONV_LATENCY = 3;
   localparam int WORD_W       = LUMA_W * PIX_PER_WORD;

   typedef logic [WORD_W-1:0] luma_word_t;
   typedef logic [$clog2(PIX_PER_WORD)-1:0] pack_idx_t;
endpackage

// File: rtl/luma_word_fifo.sv
// luma_word_fifo: synchronous FIFO for packed luma words.
// Registered occupancy count; read data reads as zero while empty.
module luma_word_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push_i,
   input  logic [W-1:0]           data_i,
   input  logic                   pop_i,
   output logic [W-1:0]           data_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          full;
   logic          do_push;
   logic          do_pop;

   assign empty_o = (cnt_q == '0);
   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign count_o = cnt_q;
   assign data_o  = empty_o ? '0 : mem_q[rd_q];

   always_comb begin
      do_pop  = pop_i && !empty_o;
      do_push = push_i && (!full || do_pop);
      wr_d    = do_push ? wr_q + AW'(1) : wr_q;
      rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_q] <= data_i;
      end
   end

   // The upstream enable rule keeps pushes away from a full FIFO.
   a_no_overflow : assert property (@(posedge clk) disable iff (reset)
      !(push_i && full && !pop_i));
endmodule

// File: rtl/luma_packer.sv
// luma_packer: converter flow control, luma packing and output FIFO.
// Define LUMA_PACK_LAST_EN to flush and tag the last word of each line.
module luma_packer
   import luma_pack_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int LINE_WIDTH = 640
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pix_valid,
   output logic              pix_ready,
   output logic              conv_enable,
   input  logic [LUMA_W-1:0] conv_luma,
   output logic [WORD_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] EN_MAX = CW'(FIFO_DEPTH - 2);
`ifdef LUMA_PACK_LAST_EN
   localparam int FW   = WORD_W + 1;
   localparam int PC_W = $clog2(LINE_WIDTH);
`else
   localparam int FW = WORD_W;
`endif

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
       || LINE_WIDTH < 2) begin : g_bad_cfg
      $error("luma_packer: unsupported parameters");
   end

   logic [CONV_LATENCY-1:0] vld_q, vld_d;
   logic       fresh_q;
   pack_idx_t  idx_q, idx_d;
   luma_word_t pack_q, pack_d;
   luma_word_t fill;
   logic       capture;
   logic       word_done;
   logic       line_end;
   logic       push;
   logic [FW-1:0] push_data;
   logic [FW-1:0] head;
   logic [CW-1:0] fifo_cnt;
   logic          fifo_empty;

   // Room for every in-flight pixel plus the partial word.
   assign conv_enable = !reset && (fifo_cnt <= EN_MAX);
   assign pix_ready   = conv_enable;
   assign capture     = fresh_q && vld_q[CONV_LATENCY-1];
   assign word_done   = (idx_q == pack_idx_t'(PIX_PER_WORD - 1));
   assign push        = capture && (word_done || line_end);

   always_comb begin
      fill = pack_q;
      fill[idx_q*LUMA_W +: LUMA_W] = conv_luma;
      vld_d  = conv_enable ? {vld_q[CONV_LATENCY-2:0], pix_valid} : vld_q;
      idx_d  = idx_q;
      pack_d = pack_q;
      if (capture) begin
         if (push) begin
            idx_d  = '0;
            pack_d = '0;
         end else begin
            idx_d  = idx_q + pack_idx_t'(1);
            pack_d = fill;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q   <= '0;
         fresh_q <= 1'b0;
         idx_q   <= '0;
         pack_q  <= '0;
      end else begin
         vld_q   <= vld_d;
         fresh_q <= conv_enable;
         idx_q   <= idx_d;
         pack_q  <= pack_d;
      end
   end

`ifdef LUMA_PACK_LAST_EN
   logic [PC_W-1:0] pix_cnt_q, pix_cnt_d;

   assign line_end = (pix_cnt_q == PC_W'(LINE_WIDTH - 1));

   always_comb begin
      pix_cnt_d = pix_cnt_q;
      if (capture) begin
         pix_cnt_d = line_end ? '0 : pix_cnt_q + PC_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pix_cnt_q <= '0;
      end else begin
         pix_cnt_q <= pix_cnt_d;
      end
   end

   // Bytes above idx are still zero from the clear after the last push.
   assign push_data = {line_end, fill};
   assign out_last  = head[WORD_W];
`else
   assign line_end  = 1'b0;
   assign push_data = fill;
   assign out_last  = 1'b0;
`endif

   luma_word_fifo #(
      .W     (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .data_i  (push_data),
      .pop_i   (out_ready),
      .data_o  (head),
      .count_o (fifo_cnt),
      .empty_o (fifo_empty)
   );

   assign out_valid = !fifo_empty;
   assign out_data  = head[WORD_W-1:0];
endmodule

// File: tb/tb_luma_packer.sv
// tb_luma_packer: converter model, byte-queue scoreboard, directed table.
// Honours LUMA_PACK_LAST_EN with a 6-pixel line.
module tb_luma_packer;
   localparam int LW = 6;
`ifdef LUMA_PACK_LAST_EN
   localparam bit LAST_EN = 1'b1;
`else
   localparam bit LAST_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pix_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        pix_ready, conv_enable, out_valid, out_last;
   logic [7:0]  conv_luma;
   logic [31:0] out_data;
   logic [7:0]  rgb = 8'h00;
   logic [7:0]  s1 = 8'h00, s2 = 8'h00, s3 = 8'h00;

   always #5 clk = ~clk;

   // Three-stage converter sharing the enable; luma equals the source value.
   always @(posedge clk) begin
      if (conv_enable) begin
         s1 <= rgb;
         s2 <= s1;
         s3 <= s2;
      end
   end
   assign conv_luma = s3;

   luma_packer #(
      .FIFO_DEPTH (4),
      .LINE_WIDTH (LW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .conv_enable (conv_enable),
      .conv_luma   (conv_luma),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_last    (out_last)
   );

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int pix_n = 0;
   int line_n = 0;
   int n_acc = 0;
   int acc4_cyc = -1;
   int first_v_cyc = -1;
   bit saw_dis = 1'b0;
   logic [7:0]  byte_q[$];
   logic [32:0] exp_q[$];
   logic [32:0] got_q[$];

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, req);
   endtask

   // Reference: pixels in accept order, grouped 4 per word (or cut at line end).
   task automatic model_accept();
      logic [7:0]  b;
      logic [31:0] w;
      bit          eol;
      b = 8'(16 + pix_n);
      pix_n++;
      n_acc++;
      if (n_acc == 4) acc4_cyc = cyc;
      byte_q.push_back(b);
      eol = LAST_EN && (line_n == LW - 1);
      line_n = (line_n == LW - 1) ? 0 : line_n + 1;
      if (byte_q.size() == 4 || eol) begin
         w = '0;
         foreach (byte_q[i]) w[i*8 +: 8] = byte_q[i];
         exp_q.push_back({eol, w});
         byte_q.delete();
      end
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (reset) begin
         byte_q.delete();
         exp_q.delete();
         pix_n  = 0;
         line_n = 0;
      end else begin
         if (!conv_enable) saw_dis = 1'b1;
         if (pix_valid && pix_ready) model_accept();
         if (out_valid && first_v_cyc < 0) first_v_cyc = cyc;
         if (out_valid && out_ready) begin
            got_q.push_back({out_last, out_data});
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL word_extra: got %0h, required no word",
                        {out_last, out_data});
            end else begin
               check("word", {out_last, out_data}, exp_q.pop_front());
            end
         end
      end
   end

   task automatic drive(bit v, bit r);
      @(posedge clk);
      #1;
      pix_valid = v;
      out_ready = r;
      rgb = v ? 8'(16 + pix_n) : 8'($urandom);
   endtask

   task automatic do_reset(int n);
      @(posedge clk);
      #1;
      reset = 1'b1;
      pix_valid = 1'b0;
      out_ready = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      reset = 1'b0;
      got_q.delete();
      n_acc = 0;
      acc4_cyc = -1;
      first_v_cyc = -1;
      saw_dis = 1'b0;
   endtask

   task automatic send(int npix, bit alt);
      int k;
      k = 0;
      while (n_acc < npix && k < 200) begin
         drive(alt ? (k % 2 == 0) : 1'b1, 1'b1);
         @(negedge clk);
         #1;
         k++;
      end
      check("accepts", n_acc, npix);
   endtask

   task automatic drain(string name);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || out_valid) && k < 200) begin
         drive(1'b0, 1'b1);
         k++;
      end
      check({name, "_left"}, exp_q.size(), 0);
      drive(1'b0, 1'b1);
      drive(1'b0, 1'b1);
      check({name, "_idle_valid"}, out_valid, 0);
      check({name, "_idle_data"}, out_data, 0);
      check({name, "_idle_last"}, out_last, 0);
   endtask

   function automatic logic [32:0] got_at(int i);
      return (got_q.size() > i) ? got_q[i] : 'x;
   endfunction

   typedef struct {
      string       name;
      int          mode;
      int          npix;
      int          exp_acc;
      int          exp_n;
      logic [31:0] w0;
      logic [31:0] w1;
      bit          l1;
   } vec_t;

   vec_t tbl[4];

   initial begin
`ifdef LUMA_PACK_LAST_EN
      tbl[0] = '{"b2b",   0, 8,  8,  2, 32'h13121110, 32'h00001514, 1'b1};
      tbl[1] = '{"alt",   1, 8,  8,  2, 32'h13121110, 32'h00001514, 1'b1};
      tbl[2] = '{"stall", 2, 40, 13, 4, 32'h13121110, 32'h00001514, 1'b1};
      tbl[3] = '{"line6", 0, 6,  6,  2, 32'h13121110, 32'h00001514, 1'b1};
`else
      tbl[0] = '{"b2b",   0, 8,  8,  2, 32'h13121110, 32'h17161514, 1'b0};
      tbl[1] = '{"alt",   1, 8,  8,  2, 32'h13121110, 32'h17161514, 1'b0};
      tbl[2] = '{"stall", 2, 40, 15, 3, 32'h13121110, 32'h17161514, 1'b0};
      tbl[3] = '{"line6", 0, 6,  6,  1, 32'h13121110, 32'h00000000, 1'b0};
`endif

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_enable", conv_enable, 0);
      check("rst_ready", pix_ready, 0);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_last", out_last, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rel_enable", conv_enable, 1);

      for (int t = 0; t < 4; t++) begin
         do_reset(2);
         if (tbl[t].mode == 2) begin
            repeat (tbl[t].npix) drive(1'b1, 1'b0);
            check({tbl[t].name, "_acc"}, n_acc, tbl[t].exp_acc);
            check({tbl[t].name, "_throttle"}, saw_dis, 1);
         end else begin
            send(tbl[t].npix, tbl[t].mode == 1);
         end
         drain(tbl[t].name);
         if (tbl[t].mode != 2) check({tbl[t].name, "_no_throttle"}, saw_dis, 0);
         if (tbl[t].mode == 0) begin
            check({tbl[t].name, "_latency"}, first_v_cyc - acc4_cyc, 4);
         end
         check({tbl[t].name, "_nwords"}, got_q.size(), tbl[t].exp_n);
         check({tbl[t].name, "_w0"}, got_at(0), {1'b0, tbl[t].w0});
         if (tbl[t].exp_n > 1) begin
            check({tbl[t].name, "_w1"}, got_at(1), {tbl[t].l1, tbl[t].w1});
         end
      end

      // Reset with two captured bytes pending: they must not reappear.
      do_reset(2);
      send(2, 1'b0);
      repeat (4) drive(1'b0, 1'b1);
      check("mid_rst_none", got_q.size(), 0);
      do_reset(1);
      send(4, 1'b0);
      drain("mid_rst");
      check("mid_rst_nwords", got_q.size(), 1);
      check("mid_rst_w0", got_at(0), {1'b0, 32'h13121110});

      // Random valid/ready traffic with one reset pulse in the middle.
      do_reset(2);
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) do_reset(1);
         drive(($urandom % 4) != 0, ($urandom % 3) != 0);
      end
      drain("rand");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
